// File: rtl/operator_arbiter_if.sv
// operator_arbiter_if: request/response bundle between the two issue lanes and the arbiter
interface operator_arbiter_if #(parameter int N = 4);
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [3:0]          req0_op;
    logic signed [N-1:0] req0_a;
    logic signed [N-1:0] req0_b;
    logic [3:0]          req1_op;
    logic signed [N-1:0] req1_a;
    logic signed [N-1:0] req1_b;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic signed [N-1:0] rsp_result;
    logic [3:0]          rsp_flags;
    logic                busy;
    modport master (
        output req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, busy
    );
    modport slave (
        input  req_valid, req0_op, req0_a, req0_b, req1_op, req1_a, req1_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, busy
    );
endinterface

// File: rtl/operator_arbiter.sv
// operator_arbiter: two-lane valid/ready arbiter sharing one Operator datapath
module operator_arbiter #(
    parameter int N             = 4,
    parameter int MULDIV_CYCLES = 3
) (
    input logic               clk,
    input logic               rst_n,
    operator_arbiter_if.slave port_if
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic [3:0]          op_q, op_d;
    logic signed [N-1:0] a_q, a_d;
    logic signed [N-1:0] b_q, b_d;
    logic signed [N-1:0] res_q, res_d;
    logic [3:0]          flags_q, flags_d;
    logic [3:0]          cnt_q, cnt_d;
    logic signed [N-1:0] y;
    logic signed [N-1:0] res;
    logic                gnt, fire, done, ill, divz;

    Operator #(.N(N)) u_op (.op_i(op_q), .a_i(a_q), .b_i(b_q), .y_o(y));

    // Grant, handshake and the special-case result override
    always_comb begin
        gnt               = &port_if.req_valid ? ~last_q : port_if.req_valid[1];
        port_if.req_ready = (rst_n && state_q == IDLE) ? port_if.req_valid & (gnt ? 2'b10 : 2'b01) : 2'b00;
        fire              = |port_if.req_ready;
        done              = (op_q == 4'd4 || op_q == 4'd5) ? cnt_q == 4'(MULDIV_CYCLES - 1) : 1'b1;
        ill               = op_q > 4'd10;
        divz              = op_q == 4'd5 && b_q == '0;
        res               = (ill || divz) ? '0 : y;
        port_if.rsp_valid  = state_q == RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
        port_if.rsp_result = res_q;
        port_if.rsp_flags  = flags_q;
        port_if.busy       = state_q != IDLE;
    end

    // Transaction sequencing: accept, execute for the op's cycle count, then hold the response
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && fire) begin
            owner_d = gnt;
            last_d  = gnt;
            op_d    = gnt ? port_if.req1_op : port_if.req0_op;
            a_d     = gnt ? port_if.req1_a : port_if.req0_a;
            b_d     = gnt ? port_if.req1_b : port_if.req0_b;
            cnt_d   = '0;
            state_d = EXEC;
        end else if (state_q == EXEC) begin
            cnt_d = cnt_q + 4'd1;
            if (done) begin
                res_d   = res;
                flags_d = {ill, divz, res[N-1], res == '0};
                state_d = RESP;
            end
        end else if (state_q == RESP && port_if.rsp_ready[owner_q]) begin
            state_d = IDLE;
        end
    end

    // State registers with synchronous active-low reset; lane 0 wins the first tie
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// Operator: combinational signed N-bit ALU shared by both lanes
module Operator #(parameter int N = 4) (
    input  logic [3:0]          op_i,
    input  logic signed [N-1:0] a_i,
    input  logic signed [N-1:0] b_i,
    output logic signed [N-1:0] y_o
);
    // Opcode decode; compare yields -1/0/+1, shifts take b as an unsigned amount
    always_comb begin
        case (op_i)
            4'd0:    y_o = a_i;
            4'd1:    y_o = (a_i < b_i) ? '1 : (a_i > b_i) ? N'(1) : '0;
            4'd2:    y_o = a_i + b_i;
            4'd3:    y_o = a_i - b_i;
            4'd4:    y_o = a_i * b_i;
            4'd5:    y_o = a_i / b_i;
            4'd6:    y_o = a_i ^ b_i;
            4'd7:    y_o = a_i & b_i;
            4'd8:    y_o = ~a_i;
            4'd9:    y_o = a_i <<< b_i;
            4'd10:   y_o = a_i >>> b_i;
            default: y_o = '0;
        endcase
    end
endmodule

// File: tb/tb_operator_arbiter.sv
// tb_operator_arbiter: directed and randomized checks against a transaction-level model
module tb_operator_arbiter;
    localparam int N  = 4;
    localparam int MC = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    operator_arbiter_if #(.N(N)) bus ();
    operator_arbiter #(.N(N), .MULDIV_CYCLES(MC)) dut (.clk(clk), .rst_n(rst_n), .port_if(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void ref_op(input int op, input int a, input int b, output logic [3:0] r, output logic [3:0] f);
        int v;
        case (op)
            0:       v = a;
            1:       v = (a < b) ? -1 : (a > b) ? 1 : 0;
            2:       v = a + b;
            3:       v = a - b;
            4:       v = a * b;
            5:       v = (b == 0) ? 0 : a / b;
            6:       v = a ^ b;
            7:       v = a & b;
            8:       v = ~a;
            9:       v = a << (b & 15);
            10:      v = a >>> (b & 15);
            default: v = 0;
        endcase
        r = v[3:0];
        f = {op > 10, op == 5 && b == 0, r[3], r == 4'd0};
    endfunction

    bit         m_infl  = 0;
    bit         m_resp  = 0;
    bit         m_last  = 1;
    bit         m_lane  = 0;
    bit         m_fresh = 1;
    int         m_op, m_a, m_b, m_wait;
    logic [3:0] m_res = 0;
    logic [3:0] m_flg = 0;

    // Model: one transaction in flight, counted down in EXEC cycles, held until its lane accepts
    always begin
        int         g;
        logic [1:0] rv;
        @(negedge clk);
        #2;
        rv = bus.req_valid;
        g  = (rv == 2'b11) ? int'(!m_last) : int'(rv[1]);
        chk("req_ready", bus.req_ready, (rst_n && !m_infl && rv != 0) ? (g ? 2 : 1) : 0);
        chk("rsp_valid", bus.rsp_valid, m_resp ? (m_lane ? 2 : 1) : 0);
        chk("busy", bus.busy, m_infl);
        if (m_resp || m_fresh) begin
            chk("rsp_result", $unsigned(bus.rsp_result), m_res);
            chk("rsp_flags", bus.rsp_flags, m_flg);
        end
        if (!rst_n) begin
            m_infl = 0; m_resp = 0; m_last = 1; m_res = 0; m_flg = 0; m_fresh = 1;
        end else if (!m_infl) begin
            if (rv != 0) begin
                m_infl = 1;
                m_lane = (g == 1);
                m_last = (g == 1);
                m_op   = g ? bus.req1_op : bus.req0_op;
                m_a    = g ? int'($signed(bus.req1_a)) : int'($signed(bus.req0_a));
                m_b    = g ? int'($signed(bus.req1_b)) : int'($signed(bus.req0_b));
                m_wait = (m_op == 4 || m_op == 5) ? MC : 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                ref_op(m_op, m_a, m_b, m_res, m_flg);
                m_resp  = 1;
                m_fresh = 0;
            end
        end else if (bus.rsp_ready[m_lane]) begin
            m_infl = 0;
            m_resp = 0;
        end
    end

    task automatic issue(input int lane, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                         output int lat, output logic [3:0] r, output logic [3:0] f);
        int k;
        @(negedge clk);
        if (lane == 1) begin
            bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        bus.req_valid = bus.req_valid | (lane == 1 ? 2'b10 : 2'b01);
        k = 0;
        #1;
        while (!bus.req_ready[lane] && k < 50) begin
            @(negedge clk); #1; k++;
        end
        chk("accept_timeout", int'(k >= 50), 0);
        @(negedge clk);
        bus.req_valid = bus.req_valid & (lane == 1 ? 2'b01 : 2'b10);
        lat = 1;
        #1;
        while (!bus.rsp_valid[lane] && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        r = $unsigned(bus.rsp_result);
        f = bus.rsp_flags;
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(negedge clk); #1;
        while (bus.busy && k < 40) begin
            @(negedge clk); #1; k++;
        end
        chk("drain_timeout", int'(k >= 40), 0);
    endtask

    initial begin
        int         lat, ng;
        int         gl [4];
        logic [3:0] r, f;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req0_op = 4'd2; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req1_op = 4'd2; bus.req1_a = 4'd1; bus.req1_b = 4'd1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_result", $unsigned(bus.rsp_result), 0);
        chk("rst_flags", bus.rsp_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;

        issue(0, 4'd2, 4'd2, 4'd3, lat, r, f);
        chk("add_lat", lat, 2); chk("add_res", r, 5); chk("add_flags", f, 4'b0000);
        issue(1, 4'd3, 4'd3, 4'd2, lat, r, f);
        chk("sub_res", r, 1); chk("sub_flags", f, 4'b0000);
        issue(1, 4'd3, 4'd2, 4'd3, lat, r, f);
        chk("subneg_res", r, 4'hF); chk("subneg_flags", f, 4'b0010);
        issue(0, 4'd4, 4'd3, 4'd2, lat, r, f);
        chk("mul_lat", lat, MC + 1); chk("mul_res", r, 6);
        issue(0, 4'd5, 4'd3, 4'd0, lat, r, f);
        chk("divz_lat", lat, MC + 1); chk("divz_res", r, 0); chk("divz_flags", f, 4'b0101);
        issue(1, 4'd13, 4'd5, 4'd3, lat, r, f);
        chk("ill_lat", lat, 2); chk("ill_res", r, 0); chk("ill_flags", f, 4'b1001);

        @(negedge clk);
        bus.req0_op = 4'd2; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req1_op = 4'd6; bus.req1_a = 4'd3; bus.req1_b = 4'd1;
        bus.req_valid = 2'b11;
        ng = 0;
        for (int k = 0; k < 40 && ng < 4; k++) begin
            #1;
            if (bus.req_ready != 0) begin
                gl[ng] = int'(bus.req_ready[1]);
                ng++;
            end
            if (bus.rsp_valid != 0) begin
                chk("tie_res", $unsigned(bus.rsp_result), 2);
                chk("tie_flags", bus.rsp_flags, 0);
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
        chk("grant_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("grant_order", gl[i], i % 2);
        drain();

        bus.rsp_ready = 2'b00;
        issue(0, 4'd9, 4'd1, 4'd2, lat, r, f);
        chk("shl_res", r, 4);
        @(negedge clk);
        bus.req1_op = 4'd2; bus.req1_a = 4'd1; bus.req1_b = 4'd1;
        bus.req_valid = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_res", $unsigned(bus.rsp_result), 4);
            chk("hold_ready", bus.req_ready, 0);
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        #1;
        chk("release_ready", bus.req_ready, 0);
        @(negedge clk);
        bus.rsp_ready = 2'b00;
        #1;
        chk("lane1_accept", bus.req_ready, 2);
        @(negedge clk);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        drain();

        @(negedge clk);
        bus.req0_op = 4'd5; bus.req0_a = 4'd7; bus.req0_b = 4'd2;
        bus.req_valid = 2'b01;
        #1;
        chk("div_accept", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("div_exec_busy", bus.busy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_result", $unsigned(bus.rsp_result), 0);
        chk("midrst_flags", bus.rsp_flags, 0);
        for (int i = 0; i < 5; i++) begin
            chk("midrst_no_rsp", bus.rsp_valid, 0);
            @(negedge clk); #1;
        end
        bus.req1_op = 4'd2; bus.req1_a = 4'd1; bus.req1_b = 4'd1;
        bus.req0_op = 4'd2; bus.req0_a = 4'd1; bus.req0_b = 4'd1;
        bus.req_valid = 2'b11;
        #1;
        chk("tie_after_reset", bus.req_ready, 1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        drain();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n         = $urandom_range(0, 149) != 0;
            bus.req_valid = 2'($urandom);
            bus.rsp_ready = 2'($urandom_range(0, 3) == 0 ? $urandom : 3);
            bus.req0_op   = 4'($urandom_range(0, 15));
            bus.req0_a    = 4'($urandom);
            bus.req0_b    = 4'($urandom);
            bus.req1_op   = 4'($urandom_range(0, 15));
            bus.req1_a    = 4'($urandom);
            bus.req1_b    = 4'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b11;
        drain();
        repeat (2) @(negedge clk);
        #3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
